fc_layer_sequencer: RTL and testbench

Control FSM that sequences one fully-connected layer pass for the 32-bit FP layer datapath (one input element per cycle broadcast to OUTPUT_NODES multiply-accumulate PEs).
- Per pass: clears the PE accumulators, streams input indices 0..INPUT_NODES-1 to the layer together with matching weight-ROM reads, and drains the PE pipeline.
- Then presents the accumulated output vector through a valid/ready handshake.
- Sits between the network-level scheduler (start/done) and the layer datapath plus its weight ROM.

---
 rtl/fc_layer_sequencer_pkg.sv | 19 +
 rtl/fc_layer_sequencer_if.sv | 38 +++
 rtl/fc_addr_delay.sv | 33 +++
 rtl/fc_layer_sequencer.sv | 140 ++++++++++++++
 tb/tb_fc_layer_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fc_layer_sequencer_pkg.sv
// Shared state encoding and constants for the fully-connected layer sequencer.
package fc_layer_sequencer_pkg;

    localparam int DATA_WIDTH = 32;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_VALID  = 3'd4
    } seq_state_t;

    // One past the last input index; the layer treats it as a zero operand.
    function automatic int feed_zero_index(input int input_nodes);
        return input_nodes;
    endfunction

endpackage

// File: rtl/fc_layer_sequencer_if.sv
// Scheduler handshake plus layer/weight-ROM control bundle for the FC layer sequencer.
interface fc_layer_sequencer_if
    import fc_layer_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH  = 11,
    parameter int WADDR_WIDTH = 11
);
    logic                   start;
    logic                   busy;
    logic                   out_valid;
    logic                   out_ready;
    logic [ADDR_WIDTH-1:0]  layer_address;
    logic                   weight_en;
    logic [WADDR_WIDTH-1:0] weight_addr;
    logic                   pe_clear;

    modport master (
        input  start,
        input  out_ready,
        output busy,
        output out_valid,
        output layer_address,
        output weight_en,
        output weight_addr,
        output pe_clear
    );

    modport slave (
        output start,
        output out_ready,
        input  busy,
        input  out_valid,
        input  layer_address,
        input  weight_en,
        input  weight_addr,
        input  pe_clear
    );
endinterface

// File: rtl/fc_addr_delay.sv
// Fixed-depth shift register that lines the layer index up with weight-ROM data.
// A depth of zero collapses to a plain wire.
module fc_addr_delay #(
    parameter int               WIDTH       = 11,
    parameter int               STAGES      = 0,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);
    generate
        if (STAGES == 0) begin : g_wire
            logic w_unused_clk_rst;
            assign w_unused_clk_rst = i_clk ^ i_reset;
            assign o_data = i_data;
        end else begin : g_pipe
            logic [WIDTH-1:0] r_pipe [STAGES];

            always_ff @(posedge i_clk) begin
                if (!i_reset) begin
                    for (int i = 0; i < STAGES; i++) r_pipe[i] <= RESET_VALUE;
                end else begin
                    r_pipe[0] <= i_data;
                    for (int i = 1; i < STAGES; i++) r_pipe[i] <= r_pipe[i-1];
                end
            end

            assign o_data = r_pipe[STAGES-1];
        end
    endgenerate
endmodule

// File: rtl/fc_layer_sequencer.sv
// Sequences one FC layer pass: clear PEs, stream indices with weight reads, drain, hand off.
// state  | meaning
// IDLE   | waiting for start, layer fed zero
// CLEAR  | one-cycle PE accumulator clear
// STREAM | weight row k issued, layer index k follows after ROM_LATENCY-1 cycles
// DRAIN  | ROM and PE pipelines empty out
// VALID  | result vector held until out_ready
module fc_layer_sequencer
    import fc_layer_sequencer_pkg::*;
#(
    parameter int INPUT_NODES = 100,
    parameter int ADDR_WIDTH  = 11,
    parameter int WADDR_WIDTH = 11,
    parameter int ROM_LATENCY = 1,
    parameter int PE_LATENCY  = 3
) (
    input logic                  i_clk,
    input logic                  i_reset,
    fc_layer_sequencer_if.master io_bus
);
    localparam int                     DRAIN_CYCLES = ROM_LATENCY + PE_LATENCY;
    localparam int                     DRAIN_W      = $clog2(DRAIN_CYCLES + 1);
    localparam logic [DRAIN_W-1:0]     DRAIN_LOAD   = DRAIN_W'(DRAIN_CYCLES - 1);
    localparam logic [WADDR_WIDTH-1:0] LAST_K       = WADDR_WIDTH'(INPUT_NODES - 1);
    localparam logic [ADDR_WIDTH-1:0]  ZERO_IDX     = ADDR_WIDTH'(feed_zero_index(INPUT_NODES));

    seq_state_t             r_state;
    seq_state_t             w_state_nxt;
    logic [DRAIN_W-1:0]     r_drain;
    logic [DRAIN_W-1:0]     w_drain_nxt;
    logic [WADDR_WIDTH-1:0] r_weight_addr;
    logic [WADDR_WIDTH-1:0] w_weight_addr_nxt;
    logic                   r_weight_en;
    logic                   w_weight_en_nxt;
    logic [ADDR_WIDTH-1:0]  r_layer_src;
    logic [ADDR_WIDTH-1:0]  w_layer_src_nxt;
    logic                   r_busy;
    logic                   w_busy_nxt;
    logic                   r_out_valid;
    logic                   w_out_valid_nxt;
    logic                   r_pe_clear;
    logic                   w_pe_clear_nxt;
    logic [ADDR_WIDTH-1:0]  w_layer_address;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state       <= S_IDLE;
            r_drain       <= '0;
            r_weight_addr <= '0;
            r_weight_en   <= 1'b0;
            r_layer_src   <= ZERO_IDX;
            r_busy        <= 1'b0;
            r_out_valid   <= 1'b0;
            r_pe_clear    <= 1'b1;
        end else begin
            r_state       <= w_state_nxt;
            r_drain       <= w_drain_nxt;
            r_weight_addr <= w_weight_addr_nxt;
            r_weight_en   <= w_weight_en_nxt;
            r_layer_src   <= w_layer_src_nxt;
            r_busy        <= w_busy_nxt;
            r_out_valid   <= w_out_valid_nxt;
            r_pe_clear    <= w_pe_clear_nxt;
        end
    end

    // Outputs are computed from the next state so every port comes straight off a flop.
    always_comb begin
        w_state_nxt       = r_state;
        w_drain_nxt       = r_drain;
        w_weight_addr_nxt = '0;
        w_weight_en_nxt   = 1'b0;
        w_layer_src_nxt   = ZERO_IDX;
        w_busy_nxt        = 1'b1;
        w_out_valid_nxt   = 1'b0;
        w_pe_clear_nxt    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (io_bus.start) w_state_nxt = S_CLEAR;
            end
            S_CLEAR: begin
                w_state_nxt = S_STREAM;
            end
            S_STREAM: begin
                if (r_weight_addr == LAST_K) begin
                    w_state_nxt = S_DRAIN;
                    w_drain_nxt = DRAIN_LOAD;
                end
            end
            S_DRAIN: begin
                if (r_drain == '0) w_state_nxt = S_VALID;
                else               w_drain_nxt = r_drain - 1'b1;
            end
            S_VALID: begin
                if (io_bus.out_ready) w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        case (w_state_nxt)
            S_IDLE: begin
                w_busy_nxt = 1'b0;
            end
            S_CLEAR: begin
                w_pe_clear_nxt = 1'b1;
            end
            S_STREAM: begin
                w_weight_en_nxt   = 1'b1;
                w_weight_addr_nxt = (r_state == S_STREAM) ? r_weight_addr + 1'b1 : '0;
                w_layer_src_nxt   = ADDR_WIDTH'(w_weight_addr_nxt);
            end
            S_VALID: begin
                w_out_valid_nxt = 1'b1;
            end
            default: begin
            end
        endcase
    end

    fc_addr_delay #(
        .WIDTH      (ADDR_WIDTH),
        .STAGES     (ROM_LATENCY - 1),
        .RESET_VALUE(ZERO_IDX)
    ) u_addr_delay (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .i_data (r_layer_src),
        .o_data (w_layer_address)
    );

    assign io_bus.busy          = r_busy;
    assign io_bus.out_valid     = r_out_valid;
    assign io_bus.layer_address = w_layer_address;
    assign io_bus.weight_en     = r_weight_en;
    assign io_bus.weight_addr   = r_weight_addr;
    assign io_bus.pe_clear      = r_pe_clear;
endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Self-checking bench: three sequencer configurations against a cycle-offset reference
// derived from the pass timeline, plus a behavioural layer for accumulated results.
module tb_fc_layer_sequencer;
    localparam int ON = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   sel = 0;
    logic drv_start = 1'b0;
    logic drv_ready = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    int cfg_n [3] = '{100, 100, 1};
    int cfg_r [3] = '{1, 3, 1};
    int cfg_p [3] = '{3, 3, 3};

    always #5 clk = ~clk;

    fc_layer_sequencer_if #(.ADDR_WIDTH(11), .WADDR_WIDTH(11)) if_a ();
    fc_layer_sequencer_if #(.ADDR_WIDTH(11), .WADDR_WIDTH(11)) if_b ();
    fc_layer_sequencer_if #(.ADDR_WIDTH(11), .WADDR_WIDTH(11)) if_c ();

    fc_layer_sequencer #(.INPUT_NODES(100), .ADDR_WIDTH(11), .WADDR_WIDTH(11),
                         .ROM_LATENCY(1), .PE_LATENCY(3))
        u_dut_a (.i_clk(clk), .i_reset(rst_n), .io_bus(if_a));
    fc_layer_sequencer #(.INPUT_NODES(100), .ADDR_WIDTH(11), .WADDR_WIDTH(11),
                         .ROM_LATENCY(3), .PE_LATENCY(3))
        u_dut_b (.i_clk(clk), .i_reset(rst_n), .io_bus(if_b));
    fc_layer_sequencer #(.INPUT_NODES(1), .ADDR_WIDTH(11), .WADDR_WIDTH(11),
                         .ROM_LATENCY(1), .PE_LATENCY(3))
        u_dut_c (.i_clk(clk), .i_reset(rst_n), .io_bus(if_c));

    assign if_a.start     = (sel == 0) && drv_start;
    assign if_b.start     = (sel == 1) && drv_start;
    assign if_c.start     = (sel == 2) && drv_start;
    assign if_a.out_ready = (sel == 0) && drv_ready;
    assign if_b.out_ready = (sel == 1) && drv_ready;
    assign if_c.out_ready = (sel == 2) && drv_ready;

    logic        obs_busy, obs_valid, obs_wen, obs_clear;
    logic [10:0] obs_waddr, obs_la;

    always_comb begin
        obs_busy  = if_c.busy;
        obs_valid = if_c.out_valid;
        obs_wen   = if_c.weight_en;
        obs_clear = if_c.pe_clear;
        obs_waddr = if_c.weight_addr;
        obs_la    = if_c.layer_address;
        if (sel == 0) begin
            obs_busy  = if_a.busy;
            obs_valid = if_a.out_valid;
            obs_wen   = if_a.weight_en;
            obs_clear = if_a.pe_clear;
            obs_waddr = if_a.weight_addr;
            obs_la    = if_a.layer_address;
        end else if (sel == 1) begin
            obs_busy  = if_b.busy;
            obs_valid = if_b.out_valid;
            obs_wen   = if_b.weight_en;
            obs_clear = if_b.pe_clear;
            obs_waddr = if_b.weight_addr;
            obs_la    = if_b.layer_address;
        end
    end

    // Behavioural layer attached to the default instance: registered input select,
    // one-cycle weight ROM, and a PE pipeline whose product lands in the accumulator.
    real x_mem [100];
    real w_mem [100][ON];
    real exp_acc [ON];
    real x_q;
    real w_q [ON];
    real p_pipe [2][ON];
    real acc [ON];
    int  la_i, wa_i;

    assign la_i = int'(if_a.layer_address);
    assign wa_i = int'(if_a.weight_addr);

    always @(posedge clk) begin
        x_q <= (la_i < 100) ? x_mem[la_i] : 0.0;
        for (int j = 0; j < ON; j++) begin
            if (if_a.weight_en && wa_i < 100) w_q[j] <= w_mem[wa_i][j];
            p_pipe[0][j] <= x_q * w_q[j];
            p_pipe[1][j] <= p_pipe[0][j];
            acc[j]       <= if_a.pe_clear ? 0.0 : acc[j] + p_pipe[1][j];
        end
    end

    task automatic run_pass(input int hold, input bit keep_start, input bit chk_acc, input string tag);
        int          n_in, lat, rl;
        logic [10:0] zero_idx, exp_la;
        logic        exp_wen;
        n_in     = cfg_n[sel];
        rl       = cfg_r[sel];
        lat      = 1 + n_in + rl + cfg_p[sel];
        zero_idx = 11'(n_in);
        drv_start = 1'b1;
        drv_ready = keep_start;
        n_checks++;
        if (obs_busy !== 1'b0) begin
            n_errors++; $display("FAIL %s idle_busy: got %b want 0", tag, obs_busy);
        end
        @(posedge clk);
        for (int n = 0; n <= lat; n++) begin
            @(negedge clk);
            if (!keep_start) drv_start = 1'b0;
            exp_wen = (n >= 1) && (n <= n_in);
            exp_la  = (n >= rl && n <= n_in + rl - 1) ? 11'(n - rl) : zero_idx;
            n_checks++;
            if (obs_busy !== 1'b1) begin
                n_errors++; $display("FAIL %s busy n=%0d: got %b want 1", tag, n, obs_busy);
            end
            n_checks++;
            if (obs_clear !== (n == 0)) begin
                n_errors++; $display("FAIL %s pe_clear n=%0d: got %b want %b", tag, n, obs_clear, n == 0);
            end
            n_checks++;
            if (obs_wen !== exp_wen) begin
                n_errors++; $display("FAIL %s weight_en n=%0d: got %b want %b", tag, n, obs_wen, exp_wen);
            end
            if (exp_wen) begin
                n_checks++;
                if (obs_waddr !== 11'(n - 1)) begin
                    n_errors++; $display("FAIL %s weight_addr n=%0d: got %0d want %0d", tag, n, obs_waddr, n - 1);
                end
            end
            n_checks++;
            if (obs_la !== exp_la) begin
                n_errors++; $display("FAIL %s layer_address n=%0d: got %0d want %0d", tag, n, obs_la, exp_la);
            end
            n_checks++;
            if (obs_valid !== (n == lat)) begin
                n_errors++; $display("FAIL %s out_valid n=%0d: got %b want %b", tag, n, obs_valid, n == lat);
            end
        end
        if (chk_acc) begin
            for (int j = 0; j < ON; j++) begin
                n_checks++;
                if (acc[j] != exp_acc[j]) begin
                    n_errors++; $display("FAIL %s acc_at_valid[%0d]: got %f want %f", tag, j, acc[j], exp_acc[j]);
                end
            end
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            n_checks++;
            if (obs_valid !== 1'b1 || obs_busy !== 1'b1 || obs_la !== zero_idx) begin
                n_errors++;
                $display("FAIL %s hold h=%0d: got valid=%b busy=%b la=%0d want 1 1 %0d",
                         tag, h, obs_valid, obs_busy, obs_la, zero_idx);
            end
        end
        if (chk_acc) begin
            for (int j = 0; j < ON; j++) begin
                n_checks++;
                if (acc[j] != exp_acc[j]) begin
                    n_errors++; $display("FAIL %s acc_after_hold[%0d]: got %f want %f", tag, j, acc[j], exp_acc[j]);
                end
            end
        end
        drv_ready = 1'b1;
        @(negedge clk);
        if (!keep_start) drv_ready = 1'b0;
        n_checks++;
        if (obs_valid !== 1'b0 || obs_busy !== 1'b0 || obs_clear !== 1'b0 || obs_la !== zero_idx) begin
            n_errors++;
            $display("FAIL %s handshake: got valid=%b busy=%b clr=%b la=%0d want 0 0 0 %0d",
                     tag, obs_valid, obs_busy, obs_clear, obs_la, zero_idx);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            n_checks++;
            if (obs_busy !== 1'b0 || obs_valid !== 1'b0 || obs_wen !== 1'b0 || obs_waddr !== 11'd0 ||
                obs_clear !== 1'b1 || obs_la !== 11'(cfg_n[s])) begin
                n_errors++;
                $display("FAIL reset_state sel=%0d: got busy=%b valid=%b wen=%b waddr=%0d clr=%b la=%0d want 0 0 0 0 1 %0d",
                         s, obs_busy, obs_valid, obs_wen, obs_waddr, obs_clear, obs_la, cfg_n[s]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        sel = 0;
        @(negedge clk);
        n_checks++;
        if (obs_clear !== 1'b0 || obs_busy !== 1'b0) begin
            n_errors++; $display("FAIL reset_release: got clr=%b busy=%b want 0 0", obs_clear, obs_busy);
        end
    endtask

    task automatic test_single_pass();
        sel = 0;
        #1;
        run_pass(0, 1'b0, 1'b0, "pass_default");
        run_pass($urandom_range(1, 6), 1'b0, 1'b0, "pass_default_hold");
    endtask

    task automatic test_datapath();
        sel = 0;
        #1;
        for (int i = 0; i < 100; i++) begin
            x_mem[i] = 1.0;
            for (int j = 0; j < ON; j++) w_mem[i][j] = 2.0;
        end
        for (int j = 0; j < ON; j++) exp_acc[j] = 200.0;
        run_pass(20, 1'b0, 1'b1, "dp_const");
        for (int i = 0; i < 100; i++) begin
            x_mem[i] = real'($urandom_range(0, 7));
            for (int j = 0; j < ON; j++) w_mem[i][j] = real'($urandom_range(0, 7)) - 3.0;
        end
        for (int j = 0; j < ON; j++) begin
            exp_acc[j] = 0.0;
            for (int i = 0; i < 100; i++) exp_acc[j] = exp_acc[j] + x_mem[i] * w_mem[i][j];
        end
        run_pass($urandom_range(0, 20), 1'b0, 1'b1, "dp_rand");
    endtask

    task automatic test_rom_latency();
        sel = 1;
        #1;
        run_pass($urandom_range(0, 4), 1'b0, 1'b0, "rom_lat3_a");
        run_pass($urandom_range(0, 4), 1'b0, 1'b0, "rom_lat3_b");
    endtask

    task automatic test_reset_mid_stream(input int k_stop);
        sel = 0;
        #1;
        drv_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        drv_start = 1'b0;
        repeat (1 + k_stop) @(negedge clk);
        n_checks++;
        if (obs_wen !== 1'b1 || obs_waddr !== 11'(k_stop)) begin
            n_errors++; $display("FAIL abort_pre k=%0d: got wen=%b waddr=%0d want 1 %0d", k_stop, obs_wen, obs_waddr, k_stop);
        end
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if (obs_busy !== 1'b0 || obs_wen !== 1'b0 || obs_la !== 11'd100 || obs_clear !== 1'b1 || obs_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL abort_state k=%0d: got busy=%b wen=%b la=%0d clr=%b valid=%b want 0 0 100 1 0",
                     k_stop, obs_busy, obs_wen, obs_la, obs_clear, obs_valid);
        end
        @(negedge clk);
        n_checks++;
        if (obs_clear !== 1'b1) begin
            n_errors++; $display("FAIL abort_clear_held: got %b want 1", obs_clear);
        end
        rst_n = 1'b1;
        @(negedge clk);
        run_pass($urandom_range(0, 3), 1'b0, 1'b0, "after_abort");
    endtask

    task automatic test_back_to_back();
        sel = 0;
        #1;
        for (int p = 0; p < 3; p++) run_pass(0, 1'b1, 1'b0, "b2b");
        drv_start = 1'b0;
        drv_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if (obs_busy !== 1'b0 || obs_clear !== 1'b0) begin
                n_errors++; $display("FAIL b2b_stop: got busy=%b clr=%b want 0 0", obs_busy, obs_clear);
            end
        end
    endtask

    task automatic test_single_input();
        sel = 2;
        #1;
        run_pass($urandom_range(0, 3), 1'b0, 1'b0, "n1_pulse");
        for (int p = 0; p < 2; p++) run_pass(0, 1'b1, 1'b0, "n1_b2b");
        drv_start = 1'b0;
        drv_ready = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_pass();
        test_datapath();
        test_rom_latency();
        test_reset_mid_stream(40);
        test_reset_mid_stream($urandom_range(0, 99));
        test_back_to_back();
        test_single_input();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
